// File: rtl/if_fetch_stage_if.sv
// Instruction-SRAM port of the fetch stage: SRAM-like req/addr_ok/data_ok protocol.
// Handshake: a request is accepted on a cycle with req & addr_ok; addr must hold steady until then.
// data_ok pulses once per accepted request, no earlier than the cycle after addr_ok.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, addr, input addr_ok, data_ok, rdata);
  modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, issues one outstanding fetch at a time and holds one {pc,inst} slot
// for ID. Redirects (br_taken_cancel) discard in-flight wrong-path fetches via a redirect buffer.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [33:0]              br_bus,
  input  logic                     id_allowin,
  output logic                     if_to_id_valid,
  output logic [63:0]              if_to_id_bus,
  if_fetch_stage_if.master         inst_sram,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] fetch_pc;
  logic        rb_valid;
  logic [31:0] rb_target;
  logic        req_from_rb;
  logic        discard;
  logic        slot_valid;
  logic [63:0] slot_bus;

  logic        cancel;
  logic [31:0] br_target;
  logic [31:0] nextpc;
  logic        slot_free;
  logic        unused_br;

  assign cancel    = br_bus[0];
  assign br_target = {br_bus[33:4], 2'b00};
  assign unused_br = ^br_bus[3:1];
  assign nextpc    = rb_valid ? rb_target : cancel ? br_target : fetch_pc + 32'd4;
  // A cancel empties the slot this cycle just like a transfer does.
  assign slot_free = !slot_valid || id_allowin || cancel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      fetch_pc    <= RESET_PC - 32'd4;
      rb_valid    <= 1'b0;
      rb_target   <= 32'd0;
      req_from_rb <= 1'b0;
      discard     <= 1'b0;
      slot_valid  <= 1'b0;
      slot_bus    <= 64'd0;
    end else begin
      if (state == S_WAIT && inst_sram.data_ok && !discard && !cancel) begin
        slot_valid <= 1'b1;
        slot_bus   <= {fetch_pc, inst_sram.rdata};
      end else if (cancel || id_allowin) begin
        slot_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (slot_free) begin
            state <= S_REQ;
            req_q <= 1'b1;
            if (cancel) begin
              addr_q      <= br_target;
              rb_valid    <= 1'b0;
              req_from_rb <= 1'b0;
            end else begin
              addr_q      <= nextpc;
              req_from_rb <= rb_valid;
            end
          end
        end
        S_REQ: begin
          // The address stays on the bus even if cancelled; its data is dropped later.
          if (cancel) begin
            discard     <= 1'b1;
            rb_valid    <= 1'b1;
            rb_target   <= br_target;
            req_from_rb <= 1'b0;
          end
          if (inst_sram.addr_ok) begin
            state    <= S_WAIT;
            req_q    <= 1'b0;
            fetch_pc <= addr_q;
            if (req_from_rb && !cancel) rb_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cancel) begin
            rb_valid  <= 1'b1;
            rb_target <= br_target;
          end
          if (inst_sram.data_ok) begin
            discard <= 1'b0;
            state   <= S_IDLE;
          end else if (cancel) begin
            discard <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign inst_sram.req  = req_q;
  assign inst_sram.addr = addr_q;
  assign if_to_id_valid = slot_valid;
  assign if_to_id_bus   = slot_bus;
  assign dbg_state      = state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: drives the SRAM port and br_bus cycle by cycle.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_REQ   = 2'd1;
  localparam logic [1:0]  ST_WAIT  = 2'd2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [33:0] br_bus;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic [1:0]  dbg_state;
  int          checks = 0;
  int          errors = 0;

  if_fetch_stage_if sram();

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .br_bus         (br_bus),
    .id_allowin     (id_allowin),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram      (sram.master),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] exp_pc, input int dly);
    int n = 0;
    while (!sram.req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {63'd0, sram.req}, 64'd1);
    chk("req_addr", {32'd0, sram.addr}, {32'd0, exp_pc});
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_held", {63'd0, sram.req}, 64'd1);
      chk("addr_held", {32'd0, sram.addr}, {32'd0, exp_pc});
    end
    sram.addr_ok = 1'b1;
    tick();
    sram.addr_ok = 1'b0;
    chk("req_drop", {63'd0, sram.req}, 64'd0);
    chk("state_wait", {62'd0, dbg_state}, {62'd0, ST_WAIT});
  endtask

  task automatic data_ret(input logic [31:0] a);
    sram.data_ok = 1'b1;
    sram.rdata   = mem(a);
    tick();
    sram.data_ok = 1'b0;
    sram.rdata   = 32'd0;
  endtask

  task automatic chk_slot(input logic [31:0] pc);
    chk("slot_valid", {63'd0, if_to_id_valid}, 64'd1);
    chk("slot_bus", if_to_id_bus, {pc, mem(pc)});
  endtask

  initial begin
    resetn       = 1'b0;
    br_bus       = 34'd0;
    id_allowin   = 1'b1;
    sram.addr_ok = 1'b0;
    sram.data_ok = 1'b0;
    sram.rdata   = 32'd0;
    repeat (3) tick();

    // reset state
    chk("rst_req", {63'd0, sram.req}, 64'd0);
    chk("rst_addr", {32'd0, sram.addr}, {32'd0, RESET_PC});
    chk("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("rst_bus", if_to_id_bus, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    resetn = 1'b1;
    tick();
    chk("first_req", {63'd0, sram.req}, 64'd1);

    // 1: in-order delivery; br_taken alone must be ignored
    do_fetch(32'h1c000000, 0);
    data_ret(32'h1c000000);
    chk_slot(32'h1c000000);
    do_fetch(32'h1c000004, 0);
    br_bus = {32'h1c000800, 1'b1, 1'b0};
    data_ret(32'h1c000004);
    br_bus = 34'd0;
    chk_slot(32'h1c000004);

    // 2: back-pressure holds the slot and blocks new requests
    id_allowin = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", {63'd0, if_to_id_valid}, 64'd1);
      chk("bp_bus", if_to_id_bus, {32'h1c000004, mem(32'h1c000004)});
      chk("bp_noreq", {63'd0, sram.req}, 64'd0);
    end
    id_allowin = 1'b1;
    tick();
    chk("bp_xfer", {63'd0, if_to_id_valid}, 64'd0);

    // 3: cancel while waiting for 1c000008
    do_fetch(32'h1c000008, 0);
    br_bus = {32'h1c000100, 1'b1, 1'b1};
    tick();
    br_bus = 34'd0;
    chk("c3_still_wait", {62'd0, dbg_state}, {62'd0, ST_WAIT});
    data_ret(32'h1c000008);
    chk("c3_dropped", {63'd0, if_to_id_valid}, 64'd0);
    do_fetch(32'h1c000100, 0);
    chk("c3_no_valid", {63'd0, if_to_id_valid}, 64'd0);
    data_ret(32'h1c000100);
    chk_slot(32'h1c000100);

    // 4: cancel in first REQ cycle, addr_ok after 3 cycles
    tick();
    chk("c4_req", {63'd0, sram.req}, 64'd1);
    chk("c4_addr", {32'd0, sram.addr}, 64'h1c000104);
    br_bus = {32'h1c000200, 1'b1, 1'b1};
    tick();
    br_bus = 34'd0;
    chk("c4_addr_hold1", {32'd0, sram.addr}, 64'h1c000104);
    tick();
    chk("c4_addr_hold2", {32'd0, sram.addr}, 64'h1c000104);
    sram.addr_ok = 1'b1;
    tick();
    sram.addr_ok = 1'b0;
    chk("c4_wait", {62'd0, dbg_state}, {62'd0, ST_WAIT});
    data_ret(32'h1c000104);
    chk("c4_dropped", {63'd0, if_to_id_valid}, 64'd0);
    do_fetch(32'h1c000200, 0);
    data_ret(32'h1c000200);
    chk_slot(32'h1c000200);

    // 5a: cancel coincides with data_ok
    do_fetch(32'h1c000204, 1);
    br_bus       = {32'h1c000300, 1'b1, 1'b1};
    sram.data_ok = 1'b1;
    sram.rdata   = mem(32'h1c000204);
    tick();
    br_bus       = 34'd0;
    sram.data_ok = 1'b0;
    chk("c5a_dropped", {63'd0, if_to_id_valid}, 64'd0);
    do_fetch(32'h1c000300, 0);
    data_ret(32'h1c000300);
    chk_slot(32'h1c000300);

    // 5b: cancel while slot valid and ID stalled
    id_allowin = 1'b0;
    tick();
    chk("c5b_held", {63'd0, if_to_id_valid}, 64'd1);
    br_bus = {32'h1c000400, 1'b1, 1'b1};
    tick();
    br_bus = 34'd0;
    chk("c5b_flushed", {63'd0, if_to_id_valid}, 64'd0);
    id_allowin = 1'b1;
    do_fetch(32'h1c000400, 0);
    data_ret(32'h1c000400);
    chk_slot(32'h1c000400);

    // PC wrap and forced-aligned redirect target
    do_fetch(32'h1c000404, 0);
    br_bus = {32'hffffffff, 1'b1, 1'b1};
    tick();
    br_bus = 34'd0;
    data_ret(32'h1c000404);
    chk("wrap_dropped", {63'd0, if_to_id_valid}, 64'd0);
    do_fetch(32'hfffffffc, 0);
    data_ret(32'hfffffffc);
    chk_slot(32'hfffffffc);
    do_fetch(32'h00000000, 0);

    // 6: reset during WAIT, late data_ok afterwards
    resetn = 1'b0;
    tick();
    chk("r6_req", {63'd0, sram.req}, 64'd0);
    chk("r6_addr", {32'd0, sram.addr}, {32'd0, RESET_PC});
    chk("r6_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("r6_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    tick();
    resetn       = 1'b1;
    sram.data_ok = 1'b1;
    sram.rdata   = 32'hdeadbeef;
    tick();
    chk("r6_req_state", {62'd0, dbg_state}, {62'd0, ST_REQ});
    tick();
    sram.data_ok = 1'b0;
    sram.rdata   = 32'd0;
    chk("r6_late_ignored", {63'd0, if_to_id_valid}, 64'd0);
    chk("r6_late_state", {62'd0, dbg_state}, {62'd0, ST_REQ});
    do_fetch(RESET_PC, 0);
    data_ret(RESET_PC);
    chk_slot(RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
